// File: rtl/sweep_sequencer_if.sv
// Bus bundle for sweep_sequencer: run control, sweep limits and status.
// With SWEEP_PRESCALE_EN defined the bundle also carries tick_div, the
// step prescale divider.
interface sweep_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             abort;
   logic             pause;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [3:0]       sweeps;
`ifdef SWEEP_PRESCALE_EN
   logic [3:0]       tick_div;
`endif
   logic [WIDTH-1:0] out;
   logic             dir;
   logic             busy;
   logic             done;
   logic             err;

   // Controller side: drives requests and limits, observes status.
   modport master (
`ifdef SWEEP_PRESCALE_EN
      output tick_div,
`endif
      output start, abort, pause, lo, hi, sweeps,
      input  out, dir, busy, done, err
   );

   // Sequencer side: consumes requests and limits, drives status.
   modport slave (
`ifdef SWEEP_PRESCALE_EN
      input  tick_div,
`endif
      input  start, abort, pause, lo, hi, sweeps,
      output out, dir, busy, done, err
   );
endinterface

// File: rtl/sweep_sequencer.sv
// Bounce counter: sweeps out between latched lo and hi limits for a latched
// number of lo->hi->lo passes, then pulses done.
// Optional feature macro SWEEP_PRESCALE_EN: adds tick_div and steps only on
// every (tick_div+1)-th unpaused cycle, timed by a down-counter.
//
// state | meaning
// IDLE  | waiting for start; out holds its last value
// UP    | incrementing out toward hi
// DOWN  | decrementing out toward lo; reaching lo ends one sweep
module sweep_sequencer #(
   parameter int WIDTH = 4
) (
   input logic              clock,
   input logic              reset,
   sweep_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [3:0]       left_q, left_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             cfg_ok;
   logic             step;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] dn_val;

   assign cfg_ok = (bus.lo < bus.hi) && (bus.sweeps != 4'd0);
   assign up_val = out_q + ONE;
   assign dn_val = out_q - ONE;

`ifdef SWEEP_PRESCALE_EN
   logic [3:0] presc_q, presc_d;

   // Step fires when the prescale down-counter hits terminal count.
   assign step = !bus.pause && (presc_q == 4'd0);

   // Prescale counter: reload on accepted start and on each step, clear on abort.
   always_comb begin
      presc_d = presc_q;
      if (state_q == IDLE) begin
         if (bus.start && cfg_ok) begin
            presc_d = bus.tick_div;
         end
      end else if (bus.abort) begin
         presc_d = 4'd0;
      end else if (!bus.pause) begin
         presc_d = (presc_q == 4'd0) ? bus.tick_div : presc_q - 4'd1;
      end
   end

   // Prescale counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q <= 4'd0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign step = !bus.pause;
`endif

   // Next-state and output decode; abort outranks pause and step.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      dir_d   = dir_q;
      busy_d  = busy_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      left_d  = left_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (cfg_ok) begin
                  lo_d    = bus.lo;
                  hi_d    = bus.hi;
                  left_d  = bus.sweeps;
                  out_d   = bus.lo;
                  dir_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = UP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         UP: begin
            if (bus.abort) begin
               busy_d  = 1'b0;
               dir_d   = 1'b0;
               state_d = IDLE;
            end else if (step) begin
               out_d = up_val;
               if (up_val == hi_q) begin
                  dir_d   = 1'b1;
                  state_d = DOWN;
               end
            end
         end
         DOWN: begin
            if (bus.abort) begin
               busy_d  = 1'b0;
               dir_d   = 1'b0;
               state_d = IDLE;
            end else if (step) begin
               out_d = dn_val;
               if (dn_val == lo_q) begin
                  left_d = left_q - 4'd1;
                  dir_d  = 1'b0;
                  if (left_q == 4'd1) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = UP;
                  end
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            dir_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any run in progress.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         out_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         left_q  <= 4'd0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         left_q  <= left_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.dir  = dir_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sweep_sequencer;

   logic clock;
   logic reset;

   sweep_sequencer_if #(.WIDTH(4)) bus ();

   sweep_sequencer #(.WIDTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: on an accepted start the whole future trajectory is
   // expanded into a queue; each step consumes one entry.
   typedef struct {
      int v;
      bit d;
   } step_t;

   step_t seq[$];
   int    m_out  = 0;
   bit    m_dir  = 0;
   bit    m_busy = 0;
   bit    m_done = 0;
   bit    m_err  = 0;
   int    m_pc   = 0;

   function automatic int tdiv();
`ifdef SWEEP_PRESCALE_EN
      return int'(bus.tick_div);
`else
      return 0;
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         m_done = 0;
         m_err  = 0;
         if (reset) begin
            m_out = 0; m_dir = 0; m_busy = 0; m_pc = 0;
            seq.delete();
         end else if (!m_busy) begin
            if (bus.start) begin
               if (bus.lo >= bus.hi || bus.sweeps == 0) begin
                  m_err = 1;
               end else begin
                  seq.delete();
                  for (int s = 0; s < int'(bus.sweeps); s++) begin
                     for (int v = int'(bus.lo) + 1; v <= int'(bus.hi); v++)
                        seq.push_back('{v: v, d: (v == int'(bus.hi))});
                     for (int v = int'(bus.hi) - 1; v >= int'(bus.lo); v--)
                        seq.push_back('{v: v, d: (v != int'(bus.lo))});
                  end
                  m_out = int'(bus.lo); m_dir = 0; m_busy = 1; m_pc = 0;
               end
            end
         end else if (bus.abort) begin
            m_busy = 0; m_dir = 0; m_pc = 0;
            seq.delete();
         end else if (!bus.pause) begin
            if (m_pc == tdiv()) begin
               step_t e;
               m_pc = 0;
               e = seq.pop_front();
               m_out = e.v;
               m_dir = e.d;
               if (seq.size() == 0) begin
                  m_busy = 0; m_dir = 0; m_done = 1;
               end
            end else begin
               m_pc++;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clock);
         check("cyc_out",  32'(bus.out),  32'(m_out));
         check("cyc_dir",  32'(bus.dir),  32'(m_dir));
         check("cyc_busy", 32'(bus.busy), 32'(m_busy));
         check("cyc_done", 32'(bus.done), 32'(m_done));
         check("cyc_err",  32'(bus.err),  32'(m_err));
         check("cyc_done_err_excl", 32'(bus.done & bus.err), 32'd0);
      end
   end

   task automatic do_start(input int l, input int h, input int s);
      @(negedge clock);
      bus.lo     = 4'(l);
      bus.hi     = 4'(h);
      bus.sweeps = 4'(s);
      bus.start  = 1'b1;
      @(negedge clock);
      bus.start  = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int k);
      k = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clock);
         if (bus.done) begin
            k = i;
            break;
         end
      end
   endtask

   int exp_basic[7] = '{2, 3, 4, 5, 4, 3, 2};
   int k;
   int prev;
   int bad;
   int held;

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
      bus.lo = '0; bus.hi = '0; bus.sweeps = '0;
`ifdef SWEEP_PRESCALE_EN
      bus.tick_div = 4'd0;
`endif
      repeat (3) @(negedge clock);
      check("rst_out",  32'(bus.out),  32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;

      // Basic run 2..5..2
      do_start(2, 5, 1);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clock);
         check("basic_out", 32'(bus.out), 32'(exp_basic[i]));
      end
      check("basic_done", 32'(bus.done), 32'd1);
      check("basic_busy", 32'(bus.busy), 32'd0);

      // Full range, two sweeps: 60 steps, never a jump other than +-1
      do_start(0, 15, 2);
      prev = 0; bad = 0; k = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clock);
         if (int'(bus.out) - prev != 1 && prev - int'(bus.out) != 1) bad++;
         prev = int'(bus.out);
         if (bus.done) begin
            k = i;
            break;
         end
      end
      check("full_done_cycle", 32'(k), 32'd60);
      check("full_no_wrap", 32'(bad), 32'd0);
      check("full_end_out", 32'(bus.out), 32'd0);

      // Rejected starts
      do_start(7, 7, 1);
      check("rej1_err",  32'(bus.err),  32'd1);
      check("rej1_busy", 32'(bus.busy), 32'd0);
      check("rej1_out",  32'(bus.out),  32'd0);
      do_start(3, 9, 0);
      check("rej2_err",  32'(bus.err),  32'd1);
      check("rej2_out",  32'(bus.out),  32'd0);
      @(negedge clock);
      check("rej2_err_clr", 32'(bus.err), 32'd0);

      // Pause for 3 cycles at out=3 while counting down
      do_start(1, 4, 1);
      k = -1; held = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clock);
         if (i == 4) begin
            check("pause_at3_dir", 32'(bus.dir), 32'd1);
            bus.pause = 1'b1;
         end
         if (i >= 4 && i <= 7 && bus.out == 4'd3) held++;
         if (i == 7) bus.pause = 1'b0;
         if (bus.done) begin
            k = i;
            break;
         end
      end
      bus.pause = 1'b0;
      check("pause_hold", 32'(held), 32'd4);
      check("pause_done_cycle", 32'(k), 32'd9);

      // Abort at out=4
      do_start(2, 6, 1);
      repeat (2) @(negedge clock);
      check("abort_pre_out", 32'(bus.out), 32'd4);
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      check("abort_out",  32'(bus.out),  32'd4);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      repeat (3) @(negedge clock);

      // Start with abort high in IDLE; mid-run start/limit changes ignored
      bus.abort = 1'b1;
      do_start(2, 4, 1);
      bus.abort = 1'b0;
      check("restart_out",  32'(bus.out),  32'd2);
      check("restart_busy", 32'(bus.busy), 32'd1);
      @(negedge clock);
      bus.lo = 4'd0; bus.hi = 4'd15; bus.sweeps = 4'd5; bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done(50, k);
      check("restart_done_cycle", 32'(k), 32'd2);
      check("restart_end_out", 32'(bus.out), 32'd2);

      // Reset mid-run
      do_start(3, 8, 2);
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst_out",  32'(bus.out),  32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_dir",  32'(bus.dir),  32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      do_start(0, 1, 1);
      wait_done(20, k);
      check("post_rst_done_cycle", 32'(k), 32'd2);

`ifdef SWEEP_PRESCALE_EN
      // Prescaled run: one step per 3 cycles
      bus.tick_div = 4'd2;
      do_start(0, 2, 1);
      k = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clock);
         if (i == 2) check("presc_out_c2", 32'(bus.out), 32'd0);
         if (i == 3) check("presc_out_c3", 32'(bus.out), 32'd1);
         if (i == 6) check("presc_out_c6", 32'(bus.out), 32'd2);
         if (bus.done) begin
            k = i;
            break;
         end
      end
      check("presc_done_cycle", 32'(k), 32'd12);
      bus.tick_div = 4'd0;
`endif

      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
